// File: rtl/core_sequencer_if.sv
// Bus bundle between the sequencer and its datapath: instruction memory,
// register-file/ALU control, the input port and status.
interface core_sequencer_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 32
);
    logic              run_i;
    logic [PC_W-1:0]   imem_addr_o;
    logic [31:0]       imem_rdata_i;
    logic [4:0]        rf_a1_o;
    logic [4:0]        rf_a2_o;
    logic [4:0]        rf_a3_o;
    logic              rf_we_o;
    logic [1:0]        rf_ws_o;
    logic [3:0]        alu_op_o;
    logic              alu_flag_i;
    logic [31:0]       se_const_o;
    logic [31:0]       in_data_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [31:0]       in_data_o;
    logic              halted_o;
    logic [CNT_W-1:0]  instr_cnt_o;

    // Sequencer side
    modport master (
        input  run_i, imem_rdata_i, alu_flag_i, in_data_i, in_valid_i,
        output imem_addr_o, rf_a1_o, rf_a2_o, rf_a3_o, rf_we_o, rf_ws_o,
               alu_op_o, se_const_o, in_ready_o, in_data_o, halted_o, instr_cnt_o
    );

    // Datapath / environment side
    modport slave (
        output run_i, imem_rdata_i, alu_flag_i, in_data_i, in_valid_i,
        input  imem_addr_o, rf_a1_o, rf_a2_o, rf_a3_o, rf_we_o, rf_ws_o,
               alu_op_o, se_const_o, in_ready_o, in_data_o, halted_o, instr_cnt_o
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the PC / imem / RF / ALU datapath.
// Owns the PC and instruction register, decodes IR fields into datapath
// controls, stalls input-port writes on a valid/ready handshake, halts on
// the illegal B&C encoding and counts retired instructions (saturating).
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | paused; PC held; leaves when run_i=1
//   FETCH   | load IR from imem (or fall back to IDLE if run_i=0)
//   EXEC    | decode IR, sample alu_flag_i, resolve branch/plain/write
//   WAIT_IN | in_ready high until in_valid_i; captures in_data_i
//   WB      | one-cycle RF write strobe, then PC+1 and retire
//   HALT    | illegal encoding seen; frozen until reset
module core_sequencer #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    core_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_WAIT_IN, S_WB, S_HALT
    } state_t;

    state_t            state, state_next;
    logic [PC_W-1:0]   pc, pc_next;
    logic [31:0]       ir;
    logic [31:0]       in_data;
    logic [CNT_W-1:0]  cnt;
    logic              ir_load, in_load, retire;

    logic              dec_b, dec_c, dec_we;
    logic [1:0]        dec_ws;
    logic [31:0]       se_const;
    logic [PC_W-1:0]   pc_inc, pc_rel;

    assign dec_b    = ir[31];
    assign dec_c    = ir[30];
    assign dec_we   = ir[29];
    assign dec_ws   = ir[28:27];
    assign se_const = {{24{ir[7]}}, ir[7:0]};

    // Branch targets are relative to the branching instruction and wrap at 2^PC_W.
    assign pc_inc = pc + PC_W'(1);
    assign pc_rel = pc + se_const[PC_W-1:0];

    // Next-state, PC update and load/retire strobes.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_load    = 1'b0;
        in_load    = 1'b0;
        retire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.run_i) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (!bus.run_i) begin
                    state_next = S_IDLE;
                end else begin
                    ir_load    = 1'b1;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (dec_b && dec_c) begin
                    state_next = S_HALT;
                end else if (dec_b) begin
                    pc_next    = pc_rel;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (dec_c) begin
                    pc_next    = bus.alu_flag_i ? pc_rel : pc_inc;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (dec_we) begin
                    state_next = (dec_ws == 2'b01) ? S_WAIT_IN : S_WB;
                end else begin
                    pc_next    = pc_inc;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_WAIT_IN: begin
                if (bus.in_valid_i) begin
                    in_load    = 1'b1;
                    state_next = S_WB;
                end
            end
            S_WB: begin
                pc_next    = pc_inc;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, PC, IR, captured input and retire counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            in_data <= '0;
            cnt     <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (ir_load) ir <= bus.imem_rdata_i;
            if (in_load) in_data <= bus.in_data_i;
            if (retire && (cnt != {CNT_W{1'b1}})) cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.imem_addr_o = pc;
    assign bus.rf_a1_o     = ir[22:18];
    assign bus.rf_a2_o     = ir[17:13];
    assign bus.rf_a3_o     = ir[12:8];
    assign bus.rf_ws_o     = dec_ws;
    assign bus.alu_op_o    = ir[26:23];
    assign bus.se_const_o  = se_const;
    assign bus.rf_we_o     = (state == S_WB);
    assign bus.in_ready_o  = (state == S_WAIT_IN);
    assign bus.in_data_o   = in_data;
    assign bus.halted_o    = (state == S_HALT);
    assign bus.instr_cnt_o = cnt;
endmodule
